score_display_ctrl: RTL and testbench
=====================================

// Module: score_display_ctrl
// PURPOSE
// Sequences the 7-segment score sprite. Collects reward/penalty events from game logic into a
// saturating pending score and commits it to the sprite only at frame boundaries (no tearing).
// On every committed change, blinks the digit for a fixed number of frames.
// Drives score[2:0] of the sprite; visible_out gates its pixel-valid in the video mux.
// PARAMETERS
// MAX_SCORE     7  saturation ceiling; legal range 1..7 (3-bit score)
// BLINK_FRAMES  8  frames per blink half-period (off or on); >=1
// BLINK_COUNT   3  off/on pairs per change notification; >=1
// PORTS
// clk_in        in   1  pixel clock; single clock domain
// rst_in        in   1  synchronous, active-high reset
// new_frame_in  in   1  1-cycle pulse at start of vertical blank
// inc_in        in   1  1-cycle reward event: pending score +1
// dec_in        in   1  1-cycle penalty event: pending score -1
// clear_in      in   1  1-cycle request: pending score to 0
// score_out     out  3  committed score to the sprite
// visible_out   out  1  1 = sprite shown, 0 = blanked (blink phase)
// busy_out      out  1  1 while a blink sequence runs (state != IDLE)
// saturated_out out  1  1 while pending == MAX_SCORE
// BEHAVIOUR
// Reset (rst_in high at a clk_in edge): pending=0, score_out=0, visible_out=1, busy_out=0,
//   state=IDLE, frame_cnt=0, blink_cnt=0. Reset overrides every input in that cycle.
// All outputs registered except saturated_out (combinational from pending).
// Pending update, every cycle, priority order:
//   clear_in -> 0; inc_in&dec_in -> unchanged; inc_in -> min(p+1,MAX_SCORE);
//   dec_in -> max(p-1,0). No wrap-around in either direction.
// Commit: on a new_frame_in cycle, compare pending *before* that cycle's event
//   (pre-edge value) with score_out. Events in the same cycle land in pending; they
//   commit at the next frame.
// FSM (frame_cnt counts new_frame_in pulses, width $clog2(BLINK_FRAMES+1)):
//   IDLE: visible_out=1. new_frame_in & pending!=score_out -> score_out<=pending,
//     frame_cnt<=0, blink_cnt<=0, visible_out<=0, -> OFF.
//   OFF: each new_frame_in frame_cnt++; when it would reach BLINK_FRAMES:
//     frame_cnt<=0, visible_out<=1, -> ON.
//   ON: each new_frame_in frame_cnt++; when it would reach BLINK_FRAMES:
//     frame_cnt<=0; if blink_cnt==BLINK_COUNT-1 -> IDLE (visible stays 1),
//     else blink_cnt++, visible_out<=0, -> OFF.
//   OFF/ON restart: a new_frame_in with pending!=score_out commits the new score and
//     restarts exactly as from IDLE. This takes priority over frame counting.
// Latency: score_out/visible_out change on the clk_in edge that samples new_frame_in.
//   New values are seen the next cycle.
// Sequence length with no further changes: 2*BLINK_FRAMES*BLINK_COUNT frames (48 default).
// No new_frame_in -> no commit and no FSM progress; pending still tracks events.
// new_frame_in with pending==score_out in IDLE: no action.
// Reset mid-sequence: returns to reset values; no residual blink.
// TESTING
// 1 reset 2 cycles -> score_out=0, visible_out=1, busy_out=0, saturated_out=0.
// 2 3x inc_in, then new_frame_in -> score_out=3, visible=0, busy=1.
//   +8 frames -> visible=1; after 48 frames total -> IDLE, busy=0, visible=1.
// 3 10x inc_in -> pending 7, saturated=1; commit -> score_out=7.
//   8x dec_in + frame -> score_out=0, no underflow.
// 4 inc_in&dec_in same cycle -> pending unchanged; clear_in&inc_in from 5 -> 0.
//   Event in the new_frame_in cycle commits only at the following frame.
// 5 score 2, 5 frames into OFF: inc_in then new_frame_in -> score_out=3, frame_cnt=0,
//   stays OFF 8 more frames; blink_cnt restarts at 0.
// 6 rst_in during ON of 2nd blink pair -> next cycle score_out=0, visible=1, busy=0.
//   100 frames without events -> stays IDLE.

Source files
------------

// File: rtl/score_display_ctrl.sv
// Purpose : collects reward/penalty events into a saturating pending score, commits it to the
//           7-segment sprite on frame boundaries only, then blinks the digit for a fixed frame count.
// Latency : score/visible/busy update on the edge that samples new_frame_in (seen next cycle);
//           saturated_out is combinational from the pending score. No backpressure: every event is absorbed.
// Ports   : clk_in/rst_in (sync, active-high); new_frame_in, inc_in, dec_in, clear_in are 1-cycle pulses;
//           score_out -> sprite digit, visible_out -> sprite pixel-valid gate, busy_out = blink in
//           progress, saturated_out = pending at MAX_SCORE.
module score_display_ctrl #(
  parameter int MAX_SCORE    = 7,
  parameter int BLINK_FRAMES = 8,
  parameter int BLINK_COUNT  = 3
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       new_frame_in,
  input  logic       inc_in,
  input  logic       dec_in,
  input  logic       clear_in,
  output logic [2:0] score_out,
  output logic       visible_out,
  output logic       busy_out,
  output logic       saturated_out
);

  localparam int FCW = $clog2(BLINK_FRAMES + 1);
  localparam int BCW = (BLINK_COUNT > 1) ? $clog2(BLINK_COUNT) : 1;

  localparam logic [FCW-1:0] FC_LAST = FCW'(BLINK_FRAMES - 1);
  localparam logic [BCW-1:0] BC_LAST = BCW'(BLINK_COUNT - 1);
  localparam logic [2:0]     MAX_S   = 3'(MAX_SCORE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OFF  = 2'd1,
    ON   = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [2:0]     pending, pending_nxt;
  logic [2:0]     score_nxt;
  logic           visible_nxt;
  logic [FCW-1:0] frame_cnt, frame_cnt_nxt;
  logic [BCW-1:0] blink_cnt, blink_cnt_nxt;

  assign saturated_out = (pending == MAX_S);

  // Pending score: clear wins, simultaneous inc/dec cancel, both directions saturate.
  always_comb begin
    pending_nxt = pending;
    if (clear_in) begin
      pending_nxt = 3'd0;
    end else if (inc_in && dec_in) begin
      pending_nxt = pending;
    end else if (inc_in) begin
      pending_nxt = (pending == MAX_S) ? pending : pending + 3'd1;
    end else if (dec_in) begin
      pending_nxt = (pending == 3'd0) ? pending : pending - 3'd1;
    end
  end

  // Blink sequencer. The commit compares the registered (pre-event) pending value, so an
  // event arriving in the frame cycle itself is held over to the next frame.
  always_comb begin
    state_nxt     = state;
    score_nxt     = score_out;
    visible_nxt   = visible_out;
    frame_cnt_nxt = frame_cnt;
    blink_cnt_nxt = blink_cnt;

    if (new_frame_in) begin
      if (pending != score_out) begin
        // A fresh change always restarts the whole notification, even mid-blink.
        score_nxt     = pending;
        frame_cnt_nxt = '0;
        blink_cnt_nxt = '0;
        visible_nxt   = 1'b0;
        state_nxt     = OFF;
      end else begin
        unique case (state)
          OFF: begin
            if (frame_cnt == FC_LAST) begin
              frame_cnt_nxt = '0;
              visible_nxt   = 1'b1;
              state_nxt     = ON;
            end else begin
              frame_cnt_nxt = frame_cnt + 1'b1;
            end
          end
          ON: begin
            if (frame_cnt == FC_LAST) begin
              frame_cnt_nxt = '0;
              if (blink_cnt == BC_LAST) begin
                visible_nxt = 1'b1;
                state_nxt   = IDLE;
              end else begin
                blink_cnt_nxt = blink_cnt + 1'b1;
                visible_nxt   = 1'b0;
                state_nxt     = OFF;
              end
            end else begin
              frame_cnt_nxt = frame_cnt + 1'b1;
            end
          end
          default: begin
            visible_nxt = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= IDLE;
      pending     <= 3'd0;
      score_out   <= 3'd0;
      visible_out <= 1'b1;
      busy_out    <= 1'b0;
      frame_cnt   <= '0;
      blink_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      pending     <= pending_nxt;
      score_out   <= score_nxt;
      visible_out <= visible_nxt;
      busy_out    <= (state_nxt != IDLE);
      frame_cnt   <= frame_cnt_nxt;
      blink_cnt   <= blink_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Purpose : self-checking bench for score_display_ctrl: directed vector table, corner-case
//           sequences, and randomized traffic against a frames-since-commit reference model.
// Latency : one check per clock step, sampled 1 time unit after the rising edge.
// Ports   : none (top-level bench).
module tb_score_display_ctrl;

  localparam int MAX_SCORE    = 7;
  localparam int BLINK_FRAMES = 8;
  localparam int BLINK_COUNT  = 3;
  localparam int SEQ_LEN      = 2 * BLINK_FRAMES * BLINK_COUNT;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic       new_frame_in = 1'b0;
  logic       inc_in = 1'b0;
  logic       dec_in = 1'b0;
  logic       clear_in = 1'b0;
  logic [2:0] score_out;
  logic       visible_out;
  logic       busy_out;
  logic       saturated_out;

  int checks = 0;
  int errors = 0;

  // Reference model: pending score, committed score, frames elapsed since the last commit.
  int m_pend  = 0;
  int m_score = 0;
  int m_since = 0;
  bit m_busy  = 1'b0;

  score_display_ctrl #(
    .MAX_SCORE   (MAX_SCORE),
    .BLINK_FRAMES(BLINK_FRAMES),
    .BLINK_COUNT (BLINK_COUNT)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .new_frame_in (new_frame_in),
    .inc_in       (inc_in),
    .dec_in       (dec_in),
    .clear_in     (clear_in),
    .score_out    (score_out),
    .visible_out  (visible_out),
    .busy_out     (busy_out),
    .saturated_out(saturated_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit       rst;
    bit       nf;
    bit       inc;
    bit       dec;
    bit       clr;
    bit [2:0] e_score;
    bit       e_vis;
    bit       e_busy;
    bit       e_sat;
  } vec_t;

  function automatic void model_update(bit r, bit nf, bit i, bit d, bit c);
    if (r) begin
      m_pend = 0; m_score = 0; m_since = 0; m_busy = 1'b0;
      return;
    end
    if (nf) begin
      if (m_pend != m_score) begin
        m_score = m_pend; m_since = 0; m_busy = 1'b1;
      end else if (m_busy) begin
        m_since++;
        if (m_since >= SEQ_LEN) m_busy = 1'b0;
      end
    end
    if (c)            m_pend = 0;
    else if (i && d)  m_pend = m_pend;
    else if (i)       m_pend = (m_pend + 1 > MAX_SCORE) ? MAX_SCORE : m_pend + 1;
    else if (d)       m_pend = (m_pend - 1 < 0) ? 0 : m_pend - 1;
  endfunction

  task automatic expect_out(string name, bit [2:0] s, bit v, bit b, bit t);
    checks++;
    if (score_out !== s || visible_out !== v || busy_out !== b || saturated_out !== t) begin
      errors++;
      $display("FAIL %s: got score=%0d vis=%0b busy=%0b sat=%0b, want score=%0d vis=%0b busy=%0b sat=%0b",
               name, score_out, visible_out, busy_out, saturated_out, s, v, b, t);
    end
  endtask

  // One clock with the given input pulses, then compare against the model.
  task automatic step(bit r, bit nf, bit i, bit d, bit c);
    bit exp_vis;
    rst_in = r; new_frame_in = nf; inc_in = i; dec_in = d; clear_in = c;
    @(posedge clk_in);
    model_update(r, nf, i, d, c);
    #1;
    rst_in = 1'b0; new_frame_in = 1'b0; inc_in = 1'b0; dec_in = 1'b0; clear_in = 1'b0;
    exp_vis = !m_busy || (((m_since / BLINK_FRAMES) % 2) == 1);
    expect_out("model", 3'(m_score), exp_vis, m_busy, (m_pend == MAX_SCORE));
  endtask

  task automatic frame();
    step(0, 1, 0, 0, 0);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0);
  endtask

  vec_t tbl[$];

  initial begin
    //          rst nf inc dec clr  score vis busy sat
    tbl.push_back('{1, 0, 0, 0, 0, 3'd0, 1, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 0, 3'd0, 1, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 0, 3'd0, 1, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 0, 3'd0, 1, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 0, 3'd0, 1, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 0, 3'd3, 0, 1, 0});  // commit 3
    tbl.push_back('{0, 0, 1, 1, 0, 3'd3, 0, 1, 0});  // inc&dec cancel
    tbl.push_back('{0, 1, 0, 0, 0, 3'd3, 0, 1, 0});  // no change, counts OFF
    tbl.push_back('{0, 0, 1, 0, 0, 3'd3, 0, 1, 0});  // pend 4
    tbl.push_back('{0, 0, 1, 0, 0, 3'd3, 0, 1, 0});  // pend 5
    tbl.push_back('{0, 0, 1, 0, 0, 3'd3, 0, 1, 0});  // pend 6
    tbl.push_back('{0, 0, 1, 0, 0, 3'd3, 0, 1, 1});  // pend 7
    tbl.push_back('{0, 0, 1, 0, 0, 3'd3, 0, 1, 1});  // stays 7
    tbl.push_back('{0, 1, 1, 0, 0, 3'd7, 0, 1, 1});  // commit 7
    tbl.push_back('{0, 0, 0, 1, 0, 3'd7, 0, 1, 0});  // pend 6
    tbl.push_back('{0, 0, 1, 0, 1, 3'd7, 0, 1, 0});  // clear beats inc
    tbl.push_back('{0, 1, 1, 0, 0, 3'd0, 0, 1, 0});  // commit 0, inc lands in pending
    tbl.push_back('{0, 1, 0, 0, 0, 3'd1, 0, 1, 0});  // held-over inc commits
    tbl.push_back('{1, 1, 1, 0, 0, 3'd0, 1, 0, 0});  // reset overrides all
    tbl.push_back('{0, 0, 0, 1, 0, 3'd0, 1, 0, 0});  // no underflow
    tbl.push_back('{0, 1, 0, 0, 0, 3'd0, 1, 0, 0});  // equal in IDLE: no action

    foreach (tbl[k]) begin
      step(tbl[k].rst, tbl[k].nf, tbl[k].inc, tbl[k].dec, tbl[k].clr);
      expect_out($sformatf("vec%0d", k), tbl[k].e_score, tbl[k].e_vis, tbl[k].e_busy, tbl[k].e_sat);
    end

    // Full blink sequence timing.
    step(1, 0, 0, 0, 0);
    repeat (3) step(0, 0, 1, 0, 0);
    frame();
    expect_out("seq_commit", 3'd3, 0, 1, 0);
    for (int f = 1; f <= SEQ_LEN; f++) begin
      idle();
      frame();
      if (f == BLINK_FRAMES - 1)  expect_out("seq_still_off", 3'd3, 0, 1, 0);
      if (f == BLINK_FRAMES)      expect_out("seq_first_on", 3'd3, 1, 1, 0);
      if (f == 2 * BLINK_FRAMES)  expect_out("seq_second_off", 3'd3, 0, 1, 0);
      if (f == SEQ_LEN - 1)       expect_out("seq_last_on", 3'd3, 1, 1, 0);
      if (f == SEQ_LEN)           expect_out("seq_done", 3'd3, 1, 0, 0);
    end

    // Saturation and underflow.
    step(1, 0, 0, 0, 0);
    repeat (10) step(0, 0, 1, 0, 0);
    expect_out("sat_pending", 3'd0, 1, 0, 1);
    frame();
    expect_out("sat_commit", 3'd7, 0, 1, 1);
    repeat (8) step(0, 0, 0, 1, 0);
    frame();
    expect_out("underflow_commit", 3'd0, 0, 1, 0);
    frame();
    expect_out("underflow_hold", 3'd0, 0, 1, 0);

    // Restart mid-OFF.
    step(1, 0, 0, 0, 0);
    repeat (2) step(0, 0, 1, 0, 0);
    frame();
    repeat (5) frame();
    step(0, 0, 1, 0, 0);
    frame();
    expect_out("restart_commit", 3'd3, 0, 1, 0);
    repeat (BLINK_FRAMES - 1) frame();
    expect_out("restart_still_off", 3'd3, 0, 1, 0);
    frame();
    expect_out("restart_on", 3'd3, 1, 1, 0);
    repeat (SEQ_LEN - BLINK_FRAMES - 1) frame();
    expect_out("restart_last", 3'd3, 1, 1, 0);
    frame();
    expect_out("restart_done", 3'd3, 1, 0, 0);

    // Reset during ON of the second pair, then a long quiet run.
    step(0, 0, 1, 0, 0);
    frame();
    repeat (3 * BLINK_FRAMES + 2) frame();
    expect_out("pair2_on", 3'd4, 1, 1, 0);
    step(1, 0, 0, 0, 0);
    expect_out("mid_reset", 3'd0, 1, 0, 0);
    for (int f = 0; f < 100; f++) begin
      frame();
      if (f == 99) expect_out("quiet_idle", 3'd0, 1, 0, 0);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 24) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
